// File: rtl/fifo_pkg.sv
// Shared constants, helpers and status payload for the synchronous FIFO family.
package fifo_pkg;

  localparam int unsigned FIFO_DATA_W = 8;
  localparam int unsigned FIFO_DEPTH  = 16;

  // Occupancy needs one extra bit so that DEPTH itself is representable
  function automatic int unsigned cnt_w(input int unsigned depth);
    return 32'($clog2(depth) + 1);
  endfunction

  typedef struct packed {
    logic empty;
    logic alm_empty;
    logic full;
    logic alm_full;
  } fifo_status_t;

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_W flop storage: synchronous write, asynchronous read, no reset.
module fifo_mem #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_W-1:0]        rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with programmable thresholds, occupancy count and sticky errors.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is registered read.
module sync_fifo_prog
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W       = FIFO_DATA_W,
  parameter int unsigned DEPTH        = FIFO_DEPTH,
  parameter int unsigned ALM_FULL_TH  = DEPTH - 2,
  parameter int unsigned ALM_EMPTY_TH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_wren,
  input  logic [DATA_W-1:0]         i_wrdata,
  input  logic                      i_rden,
  input  logic                      i_clr_err,
  output logic [DATA_W-1:0]         o_rddata,
  output logic                      o_empty,
  output logic                      o_alm_empty,
  output logic                      o_full,
  output logic                      o_alm_full,
  output logic [cnt_w(DEPTH)-1:0]   o_count,
  output logic                      o_overflow,
  output logic                      o_underflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = cnt_w(DEPTH);

  if (DATA_W < 1 || DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 ||
      ALM_EMPTY_TH < 1 || ALM_EMPTY_TH >= ALM_FULL_TH || ALM_FULL_TH >= DEPTH) begin : g_param_err
    $fatal(1, "sync_fifo_prog: illegal DATA_W/DEPTH/threshold parameters");
  end

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] mem_rdata;
  logic              wr_acc;
  logic              rd_acc;
  logic              overflow;
  logic              underflow;
  fifo_status_t      status;

  // Status decodes only from the count register
  always_comb begin
    status           = '0;
    status.empty     = (count == '0);
    status.alm_empty = (count <= CNT_W'(ALM_EMPTY_TH));
    status.full      = (count == CNT_W'(DEPTH));
    status.alm_full  = (count >= CNT_W'(ALM_FULL_TH));
  end

  assign wr_acc = i_wren && !status.full;
  assign rd_acc = i_rden && !status.empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_acc) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky errors; a new rejection beats a same-cycle clear
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (i_wren && !wr_acc)   overflow <= 1'b1;
      else if (i_clr_err)      overflow <= 1'b0;
      if (i_rden && !rd_acc)   underflow <= 1'b1;
      else if (i_clr_err)      underflow <= 1'b0;
    end
  end

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr),
    .wr_data (i_wrdata),
    .rd_addr (rd_ptr),
    .rd_data (mem_rdata)
  );

`ifdef SYNC_FIFO_FWFT_EN
  assign o_rddata = status.empty ? '0 : mem_rdata;
`else
  logic [DATA_W-1:0] rddata_q;

  always_ff @(posedge clk) begin
    if (rst)         rddata_q <= '0;
    else if (rd_acc) rddata_q <= mem_rdata;
  end

  assign o_rddata = rddata_q;
`endif

  assign o_empty     = status.empty;
  assign o_alm_empty = status.alm_empty;
  assign o_full      = status.full;
  assign o_alm_full  = status.alm_full;
  assign o_count     = count;
  assign o_overflow  = overflow;
  assign o_underflow = underflow;

endmodule

// File: doc/sync_fifo_prog.md
# sync_fifo_prog

- Parametrised single-clock FIFO; next generation of the team's synchronous FIFO.
- Adds over the previous generation:
  - configurable depth and width
  - programmable almost-full/almost-empty thresholds
  - occupancy count output
  - sticky overflow/underflow error flags
  - compile-time first-word-fall-through (FWFT) read mode
- Sits between a producer and a consumer in the same clock domain; drop-in for the existing FIFO port naming.

## Interface

Parameters:
- DATA_W, 8: data width in bits, ≥1
- DEPTH, 16: entries; power of two, ≥4
- ALM_FULL_TH, DEPTH-2: o_alm_full asserted when count ≥ this
- ALM_EMPTY_TH, 2: o_alm_empty asserted when count ≤ this
- Legal range: 1 ≤ ALM_EMPTY_TH < ALM_FULL_TH < DEPTH. Checked at elaboration; out-of-range is a fatal error.

Ports:
- clk, in, 1: sole clock; all logic on posedge.
- rst, in, 1: reset; synchronous, active-high.
- i_wren, in, 1: write request.
- i_wrdata, in, DATA_W: write data, sampled with i_wren.
- i_rden, in, 1: read request (pop).
- i_clr_err, in, 1: clears the sticky error flags.
- o_rddata, out, DATA_W: read data.
- o_empty, out, 1: count == 0.
- o_alm_empty, out, 1: count ≤ ALM_EMPTY_TH.
- o_full, out, 1: count == DEPTH.
- o_alm_full, out, 1: count ≥ ALM_FULL_TH.
- o_count, out, $clog2(DEPTH)+1: occupancy.
- o_overflow, out, 1: sticky; set when a write is rejected.
- o_underflow, out, 1: sticky; set when a read is rejected.

## Operation

- Write accepted iff i_wren && !o_full. Writes i_wrdata at wr_ptr, then increments wr_ptr.
- Read accepted iff i_rden && !o_empty. Increments rd_ptr.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Occupancy is tracked in a separate count register:
  - +1 on write only
  - -1 on read only
  - unchanged on both or neither
- Full with i_wren && i_rden: read accepted, write rejected (no write-through). o_overflow sets; count goes to DEPTH-1.
- Empty with i_wren && i_rden: write accepted, read rejected. o_underflow sets; count goes to 1.
- Error flags:
  - Rejected write sets o_overflow; rejected read sets o_underflow.
  - Both hold until i_clr_err or rst.
  - i_clr_err in the same cycle as a new error: set wins.
- All status outputs decode combinationally from the count register only. No combinational path from any input to any flag.
- Memory contents are not reset. The storage array is a flop array with asynchronous read.
- Reset values:
  - o_empty=1, o_alm_empty=1
  - o_full=0, o_alm_full=0
  - o_count=0
  - o_overflow=0, o_underflow=0
  - o_rddata=0
- Reset mid-operation: pointers, count and flags return to reset values on the next edge. Any in-flight read data is discarded. Error flags are cleared.

## Timing

- Flags and o_count update on the clock edge that accepts the operation. They are visible in the cycle after the request.
- Standard mode: o_rddata is registered.
  - It presents the popped word in the cycle after an accepted read (latency 1).
  - It holds its last value when no read is accepted.
- FWFT mode: see Configuration. Latency from write to visible data is 1 cycle (the o_empty deassertion).
- Back-to-back reads and writes are sustained at one per cycle each with no bubbles.

## Configuration

- Macro: SYNC_FIFO_FWFT_EN.
- Defined:
  - o_rddata = mem[rd_ptr] combinationally while !o_empty; 0 while o_empty.
  - The head word is valid whenever o_empty=0. i_rden acknowledges and pops it.
- Undefined: standard registered-read mode described above.
- Flag, count and error behaviour is identical in both modes.

## Structure

- Package fifo_pkg holds:
  - default parameter constants (FIFO_DATA_W=8, FIFO_DEPTH=16)
  - function cnt_w(depth) = $clog2(depth)+1
  - typedef fifo_status_t: packed struct of empty, alm_empty, full, alm_full
- One sub-module, fifo_mem: DEPTH×DATA_W storage with synchronous write and asynchronous read. Pointer, count, flag and error logic live in sync_fifo_prog.

## Test plan

Bench defaults: DATA_W=8, DEPTH=16, ALM_FULL_TH=14, ALM_EMPTY_TH=2.
- Reset check: after rst, o_empty=1, o_alm_empty=1, o_count=0, o_rddata=0, errors=0.
- Fill and drain: write 16 words 0x00..0x0F, then read 16.
  - o_alm_empty drops once count reaches 3.
  - o_alm_full rises at count=14; o_full rises at count=16.
  - Data returns 0x00..0x0F in order (latency 1 in standard mode; immediate head in FWFT).
- Overflow: at full, i_wren with 0xAA, no read → count stays 16; o_overflow=1. Then i_clr_err → o_overflow=0.
- Simultaneous at full: i_wren=i_rden=1 → count=15, o_overflow=1, the written word is lost.
- Simultaneous at empty: i_wren=i_rden=1 with 0x55 → count=1, o_underflow=1. The next read returns 0x55.
- Wrap and reset: 40 cycles of concurrent read/write at count=8 → count stays 8, data in order across pointer wrap. Then assert rst mid-stream → next cycle count=0, o_empty=1.
